bin2bcd_converter: RTL and testbench
====================================

Name: bin2bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment display controller.
- Accepts an unsigned binary value with a start pulse and converts it using shift-and-add-3 (double dabble), one bit per cycle.
- Presents a registered 4-digit packed BCD word plus an overflow flag, which feed the display controller's 16-bit data input and overflow input.
- Values above 9999 cannot be shown on four digits, so they are flagged as overflow instead of being converted.

Parameters:
- IN_W, 16, width of the binary input. Legal range is 8..16.
- MAX_VAL, 9999, largest convertible value. Any input greater than this raises overflow.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while idle.
- bin_in  input  IN_W  unsigned binary value; sampled on the edge that accepts start.
- bcd_out  output  16  packed BCD result: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- overflow  output  1  high when the last accepted input exceeded MAX_VAL.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse on the edge where bcd_out/overflow are updated.

Behaviour:
- Reset: rst low clears all registers immediately, regardless of clk.
  - Reset values: bcd_out=16'h0000, overflow=0, busy=0, done=0, state=IDLE, bit counter=0.
  - An in-flight conversion is discarded and produces no done pulse.
- Outputs: all outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE and CONV.
- IDLE, start=1 sampled at edge k:
  - If bin_in > MAX_VAL: at edge k, bcd_out<=16'hFFFF, overflow<=1, done<=1, busy stays 0, state stays IDLE. Each digit is 0xF, which the display blanks.
  - Otherwise: latch bin_in into the shift register, clear the BCD accumulator, set bit counter=IN_W-1, busy<=1, state<=CONV.
- IDLE, start=0: hold. done<=0.
- CONV, each cycle:
  - Every 4-bit accumulator digit that is >=5 gets +3.
  - Then shift {accumulator, shift register} left by one; the MSB of the binary value enters bit 0 of the ones digit.
  - Decrement the bit counter.
- CONV exit: on the edge that processes the bit with counter==0:
  - bcd_out<=final accumulator, overflow<=0, done<=1, busy<=0, state<=IDLE.
  - Conversion latency is IN_W edges: start accepted at edge k, done and bcd_out valid after edge k+IN_W.
- done: high for exactly one cycle; cleared on the next edge.
- start during CONV: ignored. bin_in is not re-sampled and no queuing occurs.
- start in the cycle done is high: accepted normally, since state is already IDLE (back-to-back operation).
- Result hold: bcd_out and overflow hold their last result until the next done. They do not change during CONV, so the display never sees partial values.
- Widths: the accumulator is 16 bits (4 digits). Only inputs <=9999 are converted, so no fifth digit is needed and no digit ever exceeds 9.
- Boundaries:
  - bin_in=0 gives 16'h0000.
  - bin_in=9999 gives 16'h9999 with overflow=0.
  - bin_in=10000 gives overflow.
  - With IN_W<14, overflow is unreachable and the comparison is constant-false.

Decomposition:
- Shared package, bcd_pkg:
  - constants BCD_DIGITS=4 and BCD_MAX=9999;
  - BLANK_WORD=16'hFFFF;
  - state enum {IDLE, CONV};
  - digit-slice index constants, shared with the display controller.
- One natural sub-module, bcd_add3: 4-bit combinational corrector (out = in>=5 ? in+3 : in), instantiated BCD_DIGITS times in the CONV datapath.

Test Plan:
- Reset: assert rst low mid-run at an arbitrary time -> all outputs 0 immediately. Release, hold start=0 for 5 cycles -> outputs stay 0 and done never pulses.
- Normal conversion: start=1 with bin_in=1234 -> busy=1 for 16 cycles, then done pulses once with bcd_out=16'h1234, overflow=0. Repeat with 0 -> 16'h0000 and 9999 -> 16'h9999.
- Overflow: bin_in=10000, then 65535 -> done one edge after start, bcd_out=16'hFFFF, overflow=1, busy never asserts. A following bin_in=42 -> bcd_out=16'h0042, overflow=0.
- Start while busy: start=1 with bin_in=5678; 3 cycles later start=1 with bin_in=1111 -> ignored; result 16'h5678, single done. Back-to-back: start raised in the done cycle with 0321 -> accepted; result 16'h0321 after 16 more cycles.
- Reset mid-conversion: start with 8765, assert rst at cycle 7 -> no done pulse and bcd_out=0. After release, start with 8765 -> correct 16'h8765.
- Randomised scoreboard (reported as a coverage scenario): 1000 random values in 0..65535 -> bcd_out matches the reference model, overflow iff value >9999, exactly one done per accepted start.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD converter and the downstream 7-segment display controller.
package bcd_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = BCD_DIGITS * DIGIT_W;

    localparam logic [15:0] BLANK_WORD = 16'hFFFF;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    // Digit slices of the packed BCD word; the display controller uses the same positions
    localparam int ONES_LSB  = 0;
    localparam int TENS_LSB  = 4;
    localparam int HUNDS_LSB = 8;
    localparam int THOUS_LSB = 12;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to any digit of 5 or more before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential shift-and-add-3 binary to 4-digit BCD converter; out-of-range inputs are
// reported as overflow with a blank word rather than converted.
module bin2bcd_converter
    import bcd_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int MAX_VAL = 9999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic [15:0]     bcd_out,
    output logic            overflow,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W = $clog2(IN_W);

    logic [0:0]       state;
    logic [IN_W-1:0]  shift_reg;
    logic [15:0]      acc;
    logic [15:0]      adj;
    logic [15:0]      next_acc;
    logic [CNT_W-1:0] bit_cnt;
    logic [31:0]      bin_ext;
    logic             too_big;

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[d*DIGIT_W +: DIGIT_W]),
            .dout (adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits shift up one place while the next binary MSB enters the ones digit
    assign next_acc = (adj << 1) | 16'(shift_reg[IN_W-1]);

    assign bin_ext = 32'(bin_in);
    assign too_big = bin_ext > 32'(MAX_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            acc       <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (too_big) begin
                            bcd_out  <= BLANK_WORD;
                            overflow <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            shift_reg <= bin_in;
                            acc       <= '0;
                            bit_cnt   <= CNT_W'(IN_W - 1);
                            busy      <= 1'b1;
                            state     <= CONV;
                        end
                    end
                end
                CONV: begin
                    acc       <= next_acc;
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    // bcd_out is only touched here so the display never sees partial digits
                    if (bit_cnt == '0) begin
                        bcd_out  <= next_acc;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: directed scenarios plus a randomized
// scoreboard against a decimal-arithmetic reference model.
module tb_bin2bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    bin2bcd_converter #(.IN_W(16), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: overflow flag in bit 16, decimal digits built with division and modulo
    function automatic logic [16:0] ref_model(input int v);
        logic [15:0] w;
        if (v > 9999) return {1'b1, 16'hFFFF};
        w[3:0]   = 4'(v % 10);
        w[7:4]   = 4'((v / 10) % 10);
        w[11:8]  = 4'((v / 100) % 10);
        w[15:12] = 4'((v / 1000) % 10);
        return {1'b0, w};
    endfunction

    // Drives start for exactly one accepting edge; returns 1ns after that edge
    task automatic start_conv(input logic [15:0] v);
        @(posedge clk); #1;
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Counts edges after the accepting edge until done shows; bounded
    task automatic wait_done(output int lat, output int busy_cnt, output bit timed_out);
        lat = 0; busy_cnt = 0; timed_out = 1'b0;
        while (!done) begin
            if (busy) busy_cnt++;
            if (lat >= 40) begin
                timed_out = 1'b1;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat, bc;
        bit to;
        int dones;
        rst = 1'b0; start = 1'b0; bin_in = '0;
        #12;
        checks++;
        if ({bcd_out, overflow, busy, done} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %h/%b/%b/%b expected 0000/0/0/0", bcd_out, overflow, busy, done);
        end
        @(negedge clk); rst = 1'b1;
        start_conv(16'd4321);
        wait_done(lat, bc, to);
        start_conv(16'd777);
        repeat (4) @(posedge clk);
        #3; rst = 1'b0;
        #1;
        checks++;
        if ({bcd_out, overflow, busy, done} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h/%b/%b/%b expected 0000/0/0/0", bcd_out, overflow, busy, done);
        end
        @(negedge clk); rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
            checks++;
            if ({bcd_out, overflow, busy} !== 18'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got %h/%b/%b expected 0000/0/0", bcd_out, overflow, busy);
            end
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got %0d expected 0", dones);
        end
    endtask

    task automatic test_normal();
        int vals[3] = '{1234, 0, 9999};
        int lat, bc;
        bit to;
        logic [16:0] exp;
        foreach (vals[i]) begin
            exp = ref_model(vals[i]);
            start_conv(16'(vals[i]));
            wait_done(lat, bc, to);
            checks++;
            if (to || lat !== 16 || bc !== 16) begin
                errors++;
                $display("[TB] FAIL normal_latency(%0d): got lat=%0d busy=%0d timeout=%b expected 16/16/0", vals[i], lat, bc, to);
            end
            checks++;
            if ({overflow, bcd_out} !== exp) begin
                errors++;
                $display("[TB] FAIL normal_value(%0d): got %b/%h expected %b/%h", vals[i], overflow, bcd_out, exp[16], exp[15:0]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || {overflow, bcd_out} !== exp) begin
                errors++;
                $display("[TB] FAIL normal_pulse(%0d): got done=%b %h expected done=0 %h", vals[i], done, bcd_out, exp[15:0]);
            end
        end
    endtask

    task automatic test_overflow();
        int vals[3] = '{10000, 65535, 42};
        int lat, bc;
        bit to;
        logic [16:0] exp;
        int exp_lat;
        foreach (vals[i]) begin
            exp = ref_model(vals[i]);
            exp_lat = exp[16] ? 0 : 16;
            start_conv(16'(vals[i]));
            wait_done(lat, bc, to);
            checks++;
            if (to || lat !== exp_lat || bc !== exp_lat) begin
                errors++;
                $display("[TB] FAIL overflow_latency(%0d): got lat=%0d busy=%0d expected %0d/%0d", vals[i], lat, bc, exp_lat, exp_lat);
            end
            checks++;
            if ({overflow, bcd_out} !== exp || (exp[16] && busy !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL overflow_value(%0d): got %b/%h busy=%b expected %b/%h", vals[i], overflow, bcd_out, busy, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        bit to;
        int dones;
        start_conv(16'd5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; bin_in = 16'd1111;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc, to);
        checks++;
        if (to || bcd_out !== 16'h5678 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ignore: got %h/%b timeout=%b expected 5678/0", bcd_out, overflow, to);
        end
        // Raise start inside the done cycle for back-to-back operation
        start = 1'b1; bin_in = 16'd321;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
        end
        wait_done(lat, bc, to);
        checks++;
        if (to || lat !== 16 || bcd_out !== 16'h0321) begin
            errors++;
            $display("[TB] FAIL b2b_value: got %h lat=%0d expected 0321 lat=16", bcd_out, lat);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_extra_done: got %0d expected 0", dones);
        end
    endtask

    task automatic test_reset_mid_conversion();
        int lat, bc;
        bit to;
        int dones;
        start_conv(16'd8765);
        repeat (6) @(posedge clk);
        #2; rst = 1'b0;
        #1;
        checks++;
        if (bcd_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got %h busy=%b done=%b expected 0000/0/0", bcd_out, busy, done);
        end
        @(negedge clk); rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || bcd_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got dones=%0d %h expected 0/0000", dones, bcd_out);
        end
        start_conv(16'd8765);
        wait_done(lat, bc, to);
        checks++;
        if (to || bcd_out !== 16'h8765 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got %h/%b expected 8765/0", bcd_out, overflow);
        end
    endtask

    task automatic test_random_scoreboard();
        int lat, bc;
        bit to;
        int v;
        logic [16:0] exp;
        int pre_errors;
        pre_errors = errors;
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
            exp = ref_model(v);
            start_conv(16'(v));
            wait_done(lat, bc, to);
            checks++;
            if (to || {overflow, bcd_out} !== exp) begin
                errors++;
                $display("[TB] FAIL random_value(%0d): got %b/%h timeout=%b expected %b/%h", v, overflow, bcd_out, to, exp[16], exp[15:0]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random_single_done(%0d): got done=%b expected 0", v, done);
            end
        end
        $display("[TB] random scoreboard coverage: 1000 values, %0d errors", errors - pre_errors);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_conversion();
        test_random_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
